// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serial-line status signals between the sensor controller and uart_tx_fifo.
interface uart_tx_fifo_if;
  logic       start;
  logic [0:7] data_in;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  modport master (output start, data_in, input tx, busy, full, overflow);
  modport slave  (input start, data_in, output tx, busy, full, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// 4-deep FIFO feeding an 8N1 UART; start bit reaches tx two cycles after the write edge, frames back-to-back.
// No backpressure: writes to a full FIFO are dropped and set sticky overflow. UART_TX_PARITY_EN adds even parity.
module uart_tx_fifo (
  input  logic          clk_9600hz,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA, PARITY, STOP_BIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;
`endif

  state_t     state, state_nxt;
  logic       start_q;
  logic [0:7] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       overflow_q;
  logic [0:7] shreg;
  logic [2:0] bit_idx, idx_nxt;
  logic       tx_q, tx_nxt;
  logic       pop;
  logic       wr, full, wr_ok, wr_drop;

  assign wr      = bus.start & ~start_q;
  assign full    = (count == 3'd4);
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign wr_ok   = wr & (~full | pop);
  assign wr_drop = wr & full & ~pop;

  always_ff @(posedge clk_9600hz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    idx_nxt   = bit_idx;
    case (state)
      IDLE: begin
        if (count != 3'd0) begin
          pop       = 1'b1;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        tx_nxt    = 1'b0;
        idx_nxt   = 3'd0;
        state_nxt = DATA;
      end
      DATA: begin
        tx_nxt  = shreg[3'd7 - bit_idx];
        idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt    = ^shreg;
        state_nxt = STOP_BIT;
      end
`endif
      STOP_BIT: begin
        if (count != 3'd0) begin
          pop       = 1'b1;
          state_nxt = START_BIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_9600hz) begin
    if (reset) begin
      start_q    <= 1'b1;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      overflow_q <= 1'b0;
      shreg      <= 8'd0;
      bit_idx    <= 3'd0;
      tx_q       <= 1'b1;
    end else begin
      start_q <= bus.start;
      bit_idx <= idx_nxt;
      tx_q    <= tx_nxt;
      if (wr_ok) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        shreg  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE) || (count != 3'd0);
  assign bus.full     = full;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-byte frame table plus burst, held-start and reset sequences.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus_if ();

  uart_tx_fifo dut (
    .clk_9600hz (clk),
    .reset      (reset),
    .bus        (bus_if)
  );

  // frame: start, data bits LSB first, [parity], stop, then one idle bit (index FL)
  typedef struct {
    logic [7:0]  data;
    logic [0:11] frame;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_err = 0;

  int         n_wr, n_tx;
  int         wr_edge [8];
  logic [7:0] wr_dat  [8];
  logic [7:0] tx_dat  [8];
  logic       full_log [128];
  logic       ovf_log  [128];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic do_reset();
    bus_if.start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_vec(input vec_t v);
    bus_if.start   = 1'b1;
    bus_if.data_in = v.data;
    tick();
    check("busy_after_write", bus_if.busy, 1'b1);
    bus_if.start   = 1'b0;
    bus_if.data_in = ~v.data;
    tick();
    check("tx_before_start", bus_if.tx, 1'b1);
    for (int k = 0; k <= FL; k++) begin
      tick();
      check($sformatf("frame_%02h_bit%0d", v.data, k), bus_if.tx, v.frame[k]);
    end
    check("busy_after_frame", bus_if.busy, 1'b0);
  endtask

  task automatic drive_for_edge(input int e);
    bus_if.start   = 1'b0;
    bus_if.data_in = 8'($urandom);
    for (int i = 0; i < n_wr; i++) begin
      if (wr_edge[i] == e) begin
        bus_if.start   = 1'b1;
        bus_if.data_in = wr_dat[i];
      end
    end
  endtask

  task automatic burst();
    int   last;
    int   j;
    logic exp;
    last = 2 + n_tx * FL;
    drive_for_edge(0);
    for (int c = 0; c <= last; c++) begin
      tick();
      full_log[c] = bus_if.full;
      ovf_log[c]  = bus_if.overflow;
      drive_for_edge(c + 1);
      if (c >= 2) begin
        j   = c - 2;
        exp = (j < n_tx * FL) ? exp_bit(tx_dat[j / FL], j % FL) : 1'b1;
        check($sformatf("burst_tx_c%0d", c), bus_if.tx, exp);
      end
    end
    bus_if.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, {1'b0, 8'b10101010, 1'b0, 2'b11}};
    vecs[1] = '{8'h07, {1'b0, 8'b11100000, 1'b1, 2'b11}};
    vecs[2] = '{8'h03, {1'b0, 8'b11000000, 1'b0, 2'b11}};
    vecs[3] = '{8'hA5, {1'b0, 8'b10100101, 1'b0, 2'b11}};
    vecs[4] = '{8'h80, {1'b0, 8'b00000001, 1'b1, 2'b11}};
    vecs[5] = '{8'hFF, {1'b0, 8'b11111111, 1'b0, 2'b11}};
    vecs[6] = '{8'h00, {1'b0, 8'b00000000, 1'b0, 2'b11}};
`else
    vecs[0] = '{8'h55, {1'b0, 8'b10101010, 3'b111}};
    vecs[1] = '{8'h07, {1'b0, 8'b11100000, 3'b111}};
    vecs[2] = '{8'h03, {1'b0, 8'b11000000, 3'b111}};
    vecs[3] = '{8'hA5, {1'b0, 8'b10100101, 3'b111}};
    vecs[4] = '{8'h80, {1'b0, 8'b00000001, 3'b111}};
    vecs[5] = '{8'hFF, {1'b0, 8'b11111111, 3'b111}};
    vecs[6] = '{8'h00, {1'b0, 8'b00000000, 3'b111}};
`endif

    // Reset with start held high across release must not produce a write.
    bus_if.start   = 1'b1;
    bus_if.data_in = 8'h55;
    reset = 1'b1;
    tick();
    tick();
    check("rst_tx", bus_if.tx, 1'b1);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_full", bus_if.full, 1'b0);
    check("rst_overflow", bus_if.overflow, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("held_start_release_busy", bus_if.busy, 1'b0);
    check("held_start_release_tx", bus_if.tx, 1'b1);
    bus_if.start = 1'b0;
    tick();

    foreach (vecs[i]) send_vec(vecs[i]);

    // start held 30 cycles with changing data: exactly one frame of the first byte.
    extra = 0;
    bus_if.start   = 1'b1;
    bus_if.data_in = 8'h3C;
    for (int c = 0; c < 30; c++) begin
      tick();
      bus_if.data_in = 8'($urandom);
      if (c >= 2 && c <= FL + 1)
        check($sformatf("held_tx_c%0d", c), bus_if.tx, exp_bit(8'h3C, c - 2));
      else if (c > FL + 1 && bus_if.tx == 1'b0)
        extra++;
    end
    check("held_extra_low_cycles", extra, 0);
    check("held_busy_end", bus_if.busy, 1'b0);
    bus_if.start = 1'b0;
    tick();

    // Six writes two cycles apart: 0x01..0x05 fit, 0x06 hits a full FIFO.
    n_wr = 6;
    n_tx = 5;
    for (int i = 0; i < 6; i++) begin
      wr_edge[i] = 2 * i;
      wr_dat[i]  = 8'(i + 1);
      tx_dat[i]  = 8'(i + 1);
    end
    burst();
    check("b1_full_c9", full_log[9], 1'b1);
    check("b1_ovf_c9", ovf_log[9], 1'b0);
    check("b1_full_at_drop", full_log[10], 1'b1);
    check("b1_ovf_c10", ovf_log[10], 1'b1);
    check("b1_full_after_pop", full_log[FL + 1], 1'b0);
    check("b1_busy_end", bus_if.busy, 1'b0);
    check("b1_ovf_sticky", bus_if.overflow, 1'b1);
    do_reset();
    check("ovf_cleared_by_reset", bus_if.overflow, 1'b0);

    // Write coinciding with a pop while full: count stays 4, nothing lost.
    n_wr = 6;
    n_tx = 6;
    for (int i = 0; i < 6; i++) begin
      wr_edge[i] = (i < 5) ? 2 * i : FL + 1;
      wr_dat[i]  = 8'(8'h11 * (i + 1));
      tx_dat[i]  = 8'(8'h11 * (i + 1));
    end
    burst();
    check("b2_full_before_pop", full_log[FL], 1'b1);
    check("b2_full_at_pop_write", full_log[FL + 1], 1'b1);
    check("b2_ovf_at_pop_write", ovf_log[FL + 1], 1'b0);
    check("b2_ovf_end", bus_if.overflow, 1'b0);
    check("b2_busy_end", bus_if.busy, 1'b0);
    do_reset();

    // Reset while data bit 3 of 0xA5 is on the line, two bytes queued behind it.
    n_wr = 3;
    wr_edge[0] = 0; wr_dat[0] = 8'hA5;
    wr_edge[1] = 2; wr_dat[1] = 8'h11;
    wr_edge[2] = 4; wr_dat[2] = 8'h22;
    drive_for_edge(0);
    for (int c = 0; c <= 6; c++) begin
      tick();
      drive_for_edge(c + 1);
      if (c >= 2) check($sformatf("abort_tx_c%0d", c), bus_if.tx, exp_bit(8'hA5, c - 2));
    end
    check("abort_full_before", bus_if.full, 1'b0);
    reset = 1'b1;
    tick();
    check("abort_tx_after_reset", bus_if.tx, 1'b1);
    check("abort_busy_after_reset", bus_if.busy, 1'b0);
    check("abort_full_after_reset", bus_if.full, 1'b0);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus_if.tx == 1'b0 || bus_if.busy == 1'b1) extra++;
    end
    check("abort_no_further_frames", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
